// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one byte per request, framed as
// start | DATA_W bits LSB first | optional parity | STOP_BITS stop bits.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   tx_start : send request, sampled only while tx_busy=0
//   tx_data  : byte captured on the accepting edge
//   tx       : serial line, idle high
//   tx_busy  : high from accepting edge until the frame ends
//   tx_done  : one-cycle pulse on the edge ending the last stop bit
module uart_tx #(
  parameter int DATA_W     = 8,
  parameter int BAUD_DIV   = 434,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_W);

  localparam logic [BW-1:0] BAUD_LAST =
    BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST =
    CW'(DATA_W - 1);
  // stop_cnt value of the final stop bit
  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic PAR_ODD   = (PARITY_ODD != 0);
  localparam logic PAR_EN    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [BW-1:0]     baud_cnt, baud_n;
  logic [CW-1:0]     bit_cnt, bit_n;
  logic              stop_cnt, stop_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              parity, parity_n;
  logic              tx_n, busy_n, done_n;
  logic              baud_end;
  logic [BW-1:0]     baud_inc;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign baud_inc = baud_end ? '0
                             : baud_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      parity   <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      stop_cnt <= stop_n;
      shift    <= shift_n;
      parity   <= parity_n;
      tx       <= tx_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_cnt;
    stop_n   = stop_cnt;
    shift_n  = shift;
    parity_n = parity;
    tx_n     = tx;
    busy_n   = tx_busy;
    done_n   = 1'b0;

    case (state)
      TX_IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (tx_start) begin
          shift_n  = tx_data;
          parity_n = (^tx_data) ^ PAR_ODD;
          state_n  = TX_START;
          tx_n     = 1'b0;
          busy_n   = 1'b1;
          baud_n   = '0;
        end
      end

      TX_START: begin
        baud_n = baud_inc;
        if (baud_end) begin
          state_n = TX_DATA;
          tx_n    = shift[0];
          bit_n   = '0;
        end
      end

      TX_DATA: begin
        baud_n = baud_inc;
        if (baud_end) begin
          if (bit_cnt == BIT_LAST) begin
            if (PAR_EN) begin
              state_n = TX_PARITY;
              tx_n    = parity;
            end else begin
              state_n = TX_STOP;
              tx_n    = 1'b1;
              stop_n  = 1'b0;
            end
          end else begin
            // tx takes the bit that the shift exposes
            shift_n = {1'b0, shift[DATA_W-1:1]};
            tx_n    = shift[1];
            bit_n   = bit_cnt + 1'b1;
          end
        end
      end

      TX_PARITY: begin
        baud_n = baud_inc;
        if (baud_end) begin
          state_n = TX_STOP;
          tx_n    = 1'b1;
          stop_n  = 1'b0;
        end
      end

      TX_STOP: begin
        baud_n = baud_inc;
        tx_n   = 1'b1;
        if (baud_end) begin
          if (stop_cnt == STOP_LAST) begin
            state_n = TX_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            stop_n = 1'b1;
          end
        end
      end

      default: begin
        state_n  = TX_IDLE;
        baud_n   = '0;
        bit_n    = '0;
        stop_n   = 1'b0;
        shift_n  = '0;
        parity_n = 1'b0;
        tx_n     = 1'b1;
        busy_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx.
// Four instances cover plain, even, odd/2-stop and full-rate setups.
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic       st   [4];
  logic [7:0] dat  [4];
  logic       txl  [4];
  logic       busy [4];
  logic       done [4];

  int n_chk;
  int n_fail;

  uart_tx #(
    .DATA_W(8), .BAUD_DIV(4), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst(rst),
    .tx_start(st[0]), .tx_data(dat[0]),
    .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_tx #(
    .DATA_W(8), .BAUD_DIV(4), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .tx_start(st[1]), .tx_data(dat[1]),
    .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );

  uart_tx #(
    .DATA_W(8), .BAUD_DIV(4), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(2)
  ) u2 (
    .clk(clk), .rst(rst),
    .tx_start(st[2]), .tx_data(dat[2]),
    .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2])
  );

  uart_tx #(
    .DATA_W(8), .BAUD_DIV(434), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u3 (
    .clk(clk), .rst(rst),
    .tx_start(st[3]), .tx_data(dat[3]),
    .tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input int idx);
    chk("idle_tx", 32'(txl[idx]), 32'd1);
    chk("idle_busy", 32'(busy[idx]), 32'd0);
    chk("idle_done", 32'(done[idx]), 32'd0);
  endtask

  task automatic idle_step(input int idx);
    step();
    idle_chk(idx);
  endtask

  // Drive a request; returns #1 after the accepting edge.
  task automatic accept(input int idx,
                        input logic [7:0] d,
                        input bit hold);
    st[idx]  = 1'b1;
    dat[idx] = d;
    step();
    if (!hold) st[idx] = 1'b0;
  endtask

  // Called #1 after the accepting edge. frame[i] is the
  // i-th bit level on the line. poke >= 0 injects a
  // 0x3C request at that cycle of the frame.
  task automatic check_frame(input int idx,
                             input logic [15:0] frame,
                             input int nbits,
                             input int baud,
                             input int poke);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < baud; c++) begin
        int cyc;
        cyc = b * baud + c;
        chk("frame_tx", 32'(txl[idx]), 32'(frame[b]));
        chk("frame_busy", 32'(busy[idx]), 32'd1);
        chk("frame_done", 32'(done[idx]), 32'd0);
        if (poke >= 0 && cyc == poke) begin
          st[idx]  = 1'b1;
          dat[idx] = 8'h3C;
        end else if (poke >= 0 && cyc == poke + 1) begin
          st[idx]  = 1'b0;
          dat[idx] = 8'hFF;
        end
        step();
      end
    end
    chk("end_done", 32'(done[idx]), 32'd1);
    chk("end_busy", 32'(busy[idx]), 32'd0);
    chk("end_tx", 32'(txl[idx]), 32'd1);
  endtask

  // Independent mid-bit sampling receiver on instance 3.
  task automatic loopback(input logic [7:0] d);
    bit         found;
    logic [7:0] r;
    logic       stop;
    bit         idle;
    found    = 0;
    r        = '0;
    stop     = 1'b0;
    st[3]    = 1'b1;
    dat[3]   = d;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (txl[3] === 1'b0) found = 1;
    end
    st[3] = 1'b0;
    chk("lb_start_seen", 32'(found), 32'd1);
    if (found) begin
      repeat (217) step();
      chk("lb_start_mid", 32'(txl[3]), 32'd0);
      for (int k = 0; k < 8; k++) begin
        repeat (434) step();
        r[k] = txl[3];
      end
      repeat (434) step();
      stop = txl[3];
      chk("lb_data", 32'(r), 32'(d));
      chk("lb_stop", 32'(stop), 32'd1);
      idle = 0;
      for (int i = 0; i < 500 && !idle; i++) begin
        step();
        if (busy[3] === 1'b0) idle = 1;
      end
      chk("lb_idle", 32'(idle), 32'd1);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st[i]  = 1'b0;
      dat[i] = 8'h00;
    end

    // reset and idle
    repeat (5) begin
      step();
      idle_chk(0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      step();
      for (int i = 0; i < 4; i++) idle_chk(i);
    end

    // 0xA5, no parity: 0|10100101|1, 40 cycles
    accept(0, 8'hA5, 0);
    check_frame(0, 16'b000000_1101001010, 10, 4, -1);
    idle_step(0);

    // even parity: 0xA5 -> 0, 0x07 -> 1, 44 cycles
    accept(1, 8'hA5, 0);
    check_frame(1, 16'b00000_10101001010, 11, 4, -1);
    idle_step(1);
    accept(1, 8'h07, 0);
    check_frame(1, 16'b00000_11000001110, 11, 4, -1);
    idle_step(1);

    // odd parity, two stop bits: 0xA5 -> 1, 48 cycles
    accept(2, 8'hA5, 0);
    check_frame(2, 16'b0000_111101001010, 12, 4, -1);
    idle_step(2);

    // request mid-frame is ignored and not queued
    accept(0, 8'h55, 0);
    check_frame(0, 16'b000000_1010101010, 10, 4, 10);
    repeat (3) idle_step(0);

    // back-to-back with tx_start held high
    accept(0, 8'h55, 1);
    dat[0] = 8'h0F;
    check_frame(0, 16'b000000_1010101010, 10, 4, -1);
    step();
    st[0] = 1'b0;
    check_frame(0, 16'b000000_1000011110, 10, 4, -1);
    idle_step(0);

    // async reset during data bit 3 of 0xF0
    accept(0, 8'hF0, 0);
    repeat (17) step();
    chk("bit3_tx", 32'(txl[0]), 32'd0);
    chk("bit3_busy", 32'(busy[0]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_tx", 32'(txl[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    repeat (3) idle_step(0);
    @(negedge clk);
    rst    = 1'b1;
    st[0]  = 1'b1;
    dat[0] = 8'h81;
    step();
    st[0] = 1'b0;
    check_frame(0, 16'b000000_1100000010, 10, 4, -1);
    idle_step(0);

    // full-rate loopback
    loopback(8'h00);
    loopback(8'hFF);
    loopback(8'h5A);
    loopback(8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter. It serialises one parallel byte per request into an asynchronous frame: start bit, LSB-first data, optional parity, stop bit(s). It is the transmit counterpart of the UART receive path and shares its bit timing, so both use the same BAUD_DIV for a given link. It holds its own baud counter, bit counter, shift register and FSM, and needs no external counters.

Parameters:
DATA_W, 8, data bits per frame (5..9)
BAUD_DIV, 434, clock cycles per bit period (>=2; 434 = 50 MHz / 115200)
PARITY_EN, 0, 1 = append parity bit after data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-low reset
tx_start  input  1  request to send; sampled only while tx_busy=0
tx_data  input  DATA_W  byte to send; captured on the accepting edge
tx  output  1  serial line; idle high
tx_busy  output  1  high from the accepting edge until the frame ends
tx_done  output  1  one-cycle pulse on the edge that ends the last stop bit

Behaviour:
- Reset (rst=0, any time, including mid-frame):
  - state=TX_IDLE; tx=1, tx_busy=0, tx_done=0; all counters and the shift register are 0.
  - A frame in progress is abandoned with no glitch low on tx.
- All outputs are registered. tx never depends combinationally on an input.
- States: TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP.
- TX_IDLE: tx=1. At an edge with tx_start=1:
  - capture tx_data into the shift register;
  - compute parity = XOR(tx_data) ^ PARITY_ODD;
  - go to TX_START with tx<=0, tx_busy<=1, baud_cnt<=0.
- Bit timing: baud_cnt counts 0..BAUD_DIV-1. Each bit level holds for exactly BAUD_DIV cycles. The state advances on the edge where baud_cnt==BAUD_DIV-1, and baud_cnt returns to 0.
- TX_START -> TX_DATA: tx<=shift[0]; bit_cnt<=0.
- TX_DATA:
  - at each bit end, shift right and tx<=next bit;
  - after bit DATA_W-1, go to TX_PARITY (tx<=parity) if PARITY_EN, else to TX_STOP (tx<=1).
- TX_PARITY -> TX_STOP: tx<=1, stop_cnt<=0.
- TX_STOP:
  - lasts STOP_BITS*BAUD_DIV cycles;
  - on its final edge: state=TX_IDLE, tx_busy<=0, tx_done<=1 for one cycle, tx stays 1.
- Frame length, from the accepting edge to the tx_done edge: (1 + DATA_W + PARITY_EN + STOP_BITS) * BAUD_DIV cycles.
- tx_start while busy: ignored, not queued. tx_data changes while busy have no effect on the frame in flight.
- Back-to-back frames:
  - tx_start held high is accepted on the first edge after tx_done, i.e. in the cycle where tx_busy=0.
  - This gives exactly 1 extra idle-high cycle between frames.
- tx_start asserted in the same cycle that reset deasserts is accepted on the first active edge.
- Counter widths: $clog2(BAUD_DIV) for baud_cnt, $clog2(DATA_W) for bit_cnt; no wrap beyond the terminal values.
- Illegal or unused state encodings recover to TX_IDLE with tx=1.

Test Plan:
1. Reset idle: rst=0 for 5 cycles, then release with tx_start=0 -> tx=1, tx_busy=0, tx_done=0 throughout; no transitions on tx.
2. Basic frame: BAUD_DIV=4, PARITY_EN=0, send 0xA5.
   - tx reads 0 | 1,0,1,0,0,1,0,1 | 1, each level 4 cycles.
   - tx_busy is high for 40 cycles.
   - tx_done pulses once, 40 cycles after the accept edge.
3. Parity: BAUD_DIV=4, PARITY_EN=1.
   - Even parity: 0xA5 gives parity bit 0, and 0x07 gives 1.
   - With PARITY_ODD=1, 0xA5 gives 1.
   - Frame is 44 cycles.
4. Busy rules and back-to-back:
   - Pulse tx_start with 0x3C mid-frame of 0x55 -> ignored; only 0x55 appears on tx.
   - Hold tx_start=1 with 0x55 then 0x0F -> second start bit begins 1 cycle after tx_done.
5. Reset mid-frame: assert rst during data bit 3 of 0xF0 -> tx=1 and tx_busy=0 immediately (async), no tx_done. After release, a new 0x81 frame transmits correctly.
6. Loopback: connect tx to the team's UART receiver with the same BAUD_DIV=434; send 0x00, 0xFF, 0x5A, 0xC3 -> the receiver recovers each byte exactly with no framing error.
